// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel frame sequencer: state encoding,
// default frame geometry and the per-frame output word count.
package sobel_pkg;

   localparam int WIDTH_DEF  = 640;
   localparam int HEIGHT_DEF = 480;
   localparam int CNT_W      = 19;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_INIT    = 3'd1,
      ST_RD_PREV = 3'd2,
      ST_RD_CURR = 3'd3,
      ST_RD_NEXT = 3'd4,
      ST_CALC    = 3'd5,
      ST_WR      = 3'd6,
      ST_DONE    = 3'd7
   } state_t;

   // Output words per frame: the top and bottom rows produce no result.
   function automatic logic [CNT_W-1:0] total_words(input int width, input int height);
      int t;
      t = (height - 2) * (width / 4);
      return t[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/sobel_seq.sv
// Frame sequencer for the Sobel filter: fetches three row words per output
// word over the memory bus, launches the datapath, then writes the result.
module sobel_seq
   import sobel_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int HEIGHT = HEIGHT_DEF
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic start_i,
   input  logic ack_i,
   input  logic calc_done_i,
   output logic offset_reset,
   output logic O_offset_cnt_en,
   output logic D_offset_cnt_en,
   output logic prev_row_load,
   output logic curr_row_load,
   output logic next_row_load,
   output logic cyc_o,
   output logic stb_o,
   output logic we_o,
   output logic calc_start_o,
   output logic done_o
);

   localparam logic [CNT_W-1:0] LAST_WORD = total_words(WIDTH, HEIGHT) - 19'd1;

   state_t            state_r;
   state_t            state_s;
   logic [CNT_W-1:0]  word_cnt;
   logic              calc_start_r;
   logic              wr_ack_s;
   logic              last_word_s;

   // Reset gates the pulse so an aborted write never advances the offsets.
   assign wr_ack_s    = (state_r == ST_WR) && ack_i && rst_n_i;
   assign last_word_s = (word_cnt == LAST_WORD);

   // State register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_s = ST_INIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_INIT: begin
            state_s = ST_RD_PREV;
         end
         ST_RD_PREV: begin
            if (ack_i) begin
               state_s = ST_RD_CURR;
            end else begin
               state_s = ST_RD_PREV;
            end
         end
         ST_RD_CURR: begin
            if (ack_i) begin
               state_s = ST_RD_NEXT;
            end else begin
               state_s = ST_RD_CURR;
            end
         end
         ST_RD_NEXT: begin
            if (ack_i) begin
               state_s = ST_CALC;
            end else begin
               state_s = ST_RD_NEXT;
            end
         end
         ST_CALC: begin
            if (calc_done_i) begin
               state_s = ST_WR;
            end else begin
               state_s = ST_CALC;
            end
         end
         ST_WR: begin
            if (ack_i) begin
               if (last_word_s) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RD_PREV;
               end
            end else begin
               state_s = ST_WR;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Output word counter; holds at the last word instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         word_cnt <= '0;
      end else if (state_r == ST_INIT) begin
         word_cnt <= '0;
      end else if (wr_ack_s && !last_word_s) begin
         word_cnt <= word_cnt + 19'd1;
      end else begin
         word_cnt <= word_cnt;
      end
   end

   // Datapath launch pulse, set only on entry into CALC.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         calc_start_r <= 1'b0;
      end else begin
         calc_start_r <= (state_r == ST_RD_NEXT) && ack_i;
      end
   end

   // State-decoded bus and control outputs
   always_comb begin
      offset_reset  = 1'b0;
      prev_row_load = 1'b0;
      curr_row_load = 1'b0;
      next_row_load = 1'b0;
      cyc_o         = 1'b0;
      stb_o         = 1'b0;
      we_o          = 1'b0;
      done_o        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            offset_reset = 1'b0;
         end
         ST_INIT: begin
            offset_reset = 1'b1;
         end
         ST_RD_PREV: begin
            cyc_o         = 1'b1;
            stb_o         = 1'b1;
            prev_row_load = 1'b1;
         end
         ST_RD_CURR: begin
            cyc_o         = 1'b1;
            stb_o         = 1'b1;
            curr_row_load = 1'b1;
         end
         ST_RD_NEXT: begin
            cyc_o         = 1'b1;
            stb_o         = 1'b1;
            next_row_load = 1'b1;
         end
         ST_CALC: begin
            cyc_o = 1'b0;
         end
         ST_WR: begin
            cyc_o = 1'b1;
            stb_o = 1'b1;
            we_o  = 1'b1;
         end
         ST_DONE: begin
            done_o = 1'b1;
         end
         default: begin
            done_o = 1'b0;
         end
      endcase
   end

   assign O_offset_cnt_en = wr_ack_s;
   assign D_offset_cnt_en = wr_ack_s;
   assign calc_start_o    = calc_start_r;

endmodule

// File: tb/tb_sobel_seq.sv
// Scoreboard bench for sobel_seq: the stimulus side queues the frame's expected
// event sequence, a negedge monitor pops and compares each observed event.
module tb_sobel_seq;

   localparam int W = 16;
   localparam int H = 4;
   localparam int T = (H - 2) * (W / 4);

   // Event codes in the order a frame produces them.
   localparam int EV_INIT = 1;
   localparam int EV_PREV = 2;
   localparam int EV_CURR = 3;
   localparam int EV_NEXT = 4;
   localparam int EV_CALC = 5;
   localparam int EV_WR   = 6;
   localparam int EV_DONE = 8;

   typedef struct {
      int code;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n_i, start_i, ack_i, calc_done_i;
   logic offset_reset, O_offset_cnt_en, D_offset_cnt_en;
   logic prev_row_load, curr_row_load, next_row_load;
   logic cyc_o, stb_o, we_o, calc_start_o, done_o;
   logic [12:0] outs;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   ev_t  q[$];

   sobel_seq #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .ack_i(ack_i),
      .calc_done_i(calc_done_i), .offset_reset(offset_reset),
      .O_offset_cnt_en(O_offset_cnt_en), .D_offset_cnt_en(D_offset_cnt_en),
      .prev_row_load(prev_row_load), .curr_row_load(curr_row_load),
      .next_row_load(next_row_load), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
      .calc_start_o(calc_start_o), .done_o(done_o)
   );

   assign outs = {offset_reset, O_offset_cnt_en, D_offset_cnt_en, prev_row_load,
                  curr_row_load, next_row_load, cyc_o, stb_o, we_o, calc_start_o,
                  done_o, 2'b00};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input int code, input int at);
      ev_t e;
      e.code = code;
      e.cyc  = at;
      q.push_back(e);
   endtask

   // Whole-frame expectation: INIT, then per word three reads, launch, write; then DONE.
   task automatic push_frame(input int c0, input bit timed);
      push_ev(EV_INIT, timed ? c0 + 1 : -1);
      for (int k = 0; k < T; k++) begin
         push_ev(EV_PREV, timed ? c0 + 2 + 5 * k : -1);
         push_ev(EV_CURR, timed ? c0 + 3 + 5 * k : -1);
         push_ev(EV_NEXT, timed ? c0 + 4 + 5 * k : -1);
         push_ev(EV_CALC, timed ? c0 + 5 + 5 * k : -1);
         push_ev(EV_WR,   timed ? c0 + 6 + 5 * k : -1);
      end
      push_ev(EV_DONE, timed ? c0 + 2 + 5 * T : -1);
   endtask

   task automatic start_frame(input bit timed);
      start_i = 1'b1;
      push_frame(cyc, timed);
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget, input bit rnd);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         if (rnd) begin
            ack_i       = ($urandom_range(0, 99) < 60);
            calc_done_i = ($urandom_range(0, 99) < 50);
            start_i     = stb_o && ($urandom_range(0, 3) == 0);
         end
         tick();
         n++;
      end
      start_i = 1'b0;
      chk_eq({name, "_drain"}, q.size(), 0);
   endtask

   task automatic wait_for(input string name, input int sel);
      int n = 0;
      while (n < 50 && !((sel == 0 && curr_row_load) || (sel == 1 && next_row_load) ||
                         (sel == 2 && we_o))) begin
         tick();
         n++;
      end
      chk_eq({name, "_found"}, (n < 50) ? 1 : 0, 1);
   endtask

   // Monitor: per-cycle invariants plus in-order event comparison.
   always @(negedge clk) begin
      int  code;
      ev_t e;
      code = 0;
      if (!rst_n_i) begin
         chk_eq("rst_cnt_en", {O_offset_cnt_en, D_offset_cnt_en}, 0);
         q.delete();
      end else begin
         if (O_offset_cnt_en || D_offset_cnt_en)
            chk_eq("cnt_en_ctx", {O_offset_cnt_en, D_offset_cnt_en, stb_o, we_o, ack_i,
                                  offset_reset}, 6'b111110);
         if (stb_o) begin
            chk_eq("row_sel", $countones({prev_row_load, curr_row_load, next_row_load}),
                   we_o ? 0 : 1);
            chk_eq("cyc_with_stb", cyc_o, 1);
         end
         if (stb_o && we_o && ack_i)
            chk_eq("wr_cnt_en", {O_offset_cnt_en, D_offset_cnt_en}, 3);
         if (offset_reset) code = EV_INIT;
         else if (stb_o && ack_i && !we_o)
            code = prev_row_load ? EV_PREV : curr_row_load ? EV_CURR : next_row_load ? EV_NEXT : 9;
         else if (calc_start_o) code = EV_CALC;
         else if (stb_o && ack_i && we_o) code = EV_WR;
         else if (done_o) code = EV_DONE;
         if (code != 0) begin
            if (q.size() == 0) begin
               chk_eq("unexpected_event", code, 0);
            end else begin
               e = q.pop_front();
               chk_eq("event_order", code, e.code);
               if (e.cyc >= 0) chk_eq("event_cycle", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      int held;
      rst_n_i = 1'b0; start_i = 1'b1; ack_i = 1'b0; calc_done_i = 1'b0;
      repeat (3) begin
         tick();
         chk_eq("reset_outs", outs, 0);
      end
      rst_n_i = 1'b1; start_i = 1'b0;
      tick();
      chk_eq("idle_outs", outs, 0);

      // Best-case frame with exact event cycles.
      ack_i = 1'b1; calc_done_i = 1'b1;
      start_frame(1'b1);
      wait_drain("timed", 100, 1'b0);
      chk_eq("idle_after_done", outs, 0);

      // ack in IDLE must not produce any event.
      repeat (4) begin
         tick();
         chk_eq("idle_ack_ignored", outs, 0);
      end

      // Stall the first RD_CURR for 3 cycles.
      start_frame(1'b0);
      wait_for("stall", 0);
      ack_i = 1'b0;
      held = 0;
      repeat (3) begin
         if (curr_row_load && stb_o) held++;
         tick();
      end
      ack_i = 1'b1;
      if (curr_row_load && stb_o) held++;
      tick();
      chk_eq("stall_hold", held, 4);
      chk_eq("after_stall_next", next_row_load, 1);
      wait_drain("stall", 200, 1'b0);

      // start pulsed while busy is ignored.
      start_frame(1'b0);
      wait_for("busy_start", 1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_drain("busy_start", 200, 1'b0);

      // Randomised handshakes.
      repeat (4) begin
         start_frame(1'b0);
         wait_drain("random", 2000, 1'b1);
         ack_i = 1'b0; calc_done_i = 1'b0;
         tick();
      end

      // Reset during a write with ack, then a clean timed restart.
      ack_i = 1'b1; calc_done_i = 1'b1;
      start_frame(1'b0);
      tick();
      wait_for("rst_in_wr", 2);
      rst_n_i = 1'b0;
      @(negedge clk);
      chk_eq("rst_wr_no_cnt_en", {O_offset_cnt_en, D_offset_cnt_en}, 0);
      tick();
      rst_n_i = 1'b1;
      chk_eq("post_rst_idle", outs, 0);
      tick();
      start_frame(1'b1);
      wait_drain("restart", 100, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
